uart8_receiver: RTL and testbench

8-bit UART receiver, the receive-side counterpart of the team's 8-bit transmitter (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Clocked at OVERSAMPLE x baud rate, unlike the transmitter, which runs at baud rate. This allows mid-bit sampling of an asynchronous line.
- Presents each received byte with a one-cycle done pulse and flags framing errors.
- Sits between the rx pad and the byte-consuming logic.

---
 rtl/uart8_receiver_pkg.sv | 17 +
 rtl/uart_sync.sv | 33 +++
 rtl/uart8_receiver.sv | 147 ++++++++++++++
 tb/tb_uart8_receiver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_receiver_pkg.sv
// Shared UART definitions: frame state encodings (same as the transmitter) and line constants.
// No logic, no latency; no flow control.
// Imported by every rx/tx block so state encodings stay consistent across the pair.
package uart8_receiver_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'b000,
        ST_IDLE      = 3'b001,
        ST_START_BIT = 3'b010,
        ST_DATA_BITS = 3'b011,
        ST_STOP_BIT  = 3'b100
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous serial line; resets to the idle level.
// Latency: STAGES clk cycles.
// No backpressure: samples every cycle.
module uart_sync
    import uart8_receiver_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Reset to the idle level so a released reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{UART_IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver clocked at OVERSAMPLE x baud, mid-bit sampling, done/err pulses.
// Latency: done/err 9*OVERSAMPLE + OVERSAMPLE/2 + 1 cycles after the synchronized start edge.
// No backpressure: out holds the last good byte until the next good frame overwrites it.
module uart8_receiver
    import uart8_receiver_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in,
    output logic [UART_DATA_BITS-1:0] out,
    output logic                      done,
    output logic                      busy,
    output logic                      err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic rxs;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in),
        .q     (rxs)
    );

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] out_q, out_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;
    logic                      rxp_q, rxp_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rxp_d     = rxs;

        case (state_q)
            ST_IDLE: begin
                busy_d    = 1'b0;
                cnt_d     = '0;
                bit_idx_d = '0;
                // Edge, not level: a line stuck low after a framing error must not retrigger.
                if (en && rxp_q && !rxs) begin
                    state_d = ST_START_BIT;
                    busy_d  = 1'b1;
                end
            end
            ST_START_BIT: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = ST_DATA_BITS;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA_BITS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP_BIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (rxs) begin
                        out_d  = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            rxp_q     <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            rxp_q     <= rxp_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed frames against a frame-level timing model; one per-cycle compare process plus literal checks.
module tb_uart8_receiver;

    localparam int OS   = 16;
    localparam int SYNC = 2;
    // Drive-to-pulse latency: synchronizer, then 9.5 bit periods plus one register stage.
    localparam int LAT  = SYNC + 9 * OS + OS / 2 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       in = 1'b1;
    logic [7:0] out;
    logic       done, busy, err;

    uart8_receiver #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .out   (out),
        .done  (done),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         lo;
        int         hi;
        int         evt;
        bit         has_evt;
        bit         is_done;
        logic [7:0] val;
    } win_t;

    win_t       wins[$];
    logic [7:0] exp_out = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cnt_done, cnt_err, cnt_busy;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cyc %0d", name, act, act, req, req, cyc);
        end
    endtask

    task automatic idle(input int n);
        in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic frame_level(input logic [7:0] b, input logic stop, input int i);
        logic lvl;
        if (i == 0) lvl = 1'b0;
        else if (i == 9) lvl = stop;
        else lvl = b[i-1];
        return lvl;
    endfunction

    task automatic add_frame(input int c0, input logic [7:0] b, input logic stop);
        win_t w;
        w.lo      = c0 + SYNC + 1;
        w.hi      = c0 + LAT - 1;
        w.evt     = c0 + LAT;
        w.has_evt = 1'b1;
        w.is_done = stop;
        w.val     = b;
        wins.push_back(w);
    endtask

    // Full 10-bit frame; en drops at bit drop_bit (negative: never).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int drop_bit);
        if (en) add_frame(cyc, b, stop);
        for (int i = 0; i < 10; i++) begin
            in = frame_level(b, stop, i);
            if (i == drop_bit) en = 1'b0;
            repeat (OS) @(negedge clk);
        end
    endtask

    task automatic zero_counts();
        cnt_done = 0;
        cnt_err  = 0;
        cnt_busy = 0;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        in    = 1'b1;
        wins.delete();
        exp_out = 8'h00;
        #1;
        check("rst_out", int'(out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        zero_counts();
        #1;
        check("init_out", int'(out), 0);
        check("init_busy", int'(busy), 0);
        check("init_done", int'(done), 0);
        check("init_err", int'(err), 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        fork
            forever begin
                @(negedge clk);
                begin
                    logic e_busy, e_done, e_err;
                    e_busy = 1'b0;
                    e_done = 1'b0;
                    e_err  = 1'b0;
                    foreach (wins[k]) begin
                        if (cyc >= wins[k].lo && cyc <= wins[k].hi) e_busy = 1'b1;
                        if (wins[k].has_evt && cyc == wins[k].evt) begin
                            if (wins[k].is_done) begin
                                e_done  = 1'b1;
                                exp_out = wins[k].val;
                            end else begin
                                e_err = 1'b1;
                            end
                        end
                    end
                    check("cyc_busy", int'(busy), int'(e_busy));
                    check("cyc_done", int'(done), int'(e_done));
                    check("cyc_err", int'(err), int'(e_err));
                    check("cyc_out", int'(out), int'(exp_out));
                    cnt_done += int'(done);
                    cnt_err  += int'(err);
                    cnt_busy += int'(busy);
                end
            end
        join_none

        idle(8);

        // Single good frame
        zero_counts();
        send_frame(8'hA5, 1'b1, -1);
        idle(8);
        check("a5_out", int'(out), 'hA5);
        check("a5_done_cnt", cnt_done, 1);
        check("a5_err_cnt", cnt_err, 0);
        check("a5_busy_cycles", cnt_busy, 152);

        // Back-to-back, no gap beyond the stop bit
        zero_counts();
        send_frame(8'h00, 1'b1, -1);
        check("b2b_first_out", int'(out), 'h00);
        send_frame(8'hFF, 1'b1, -1);
        idle(8);
        check("b2b_done_cnt", cnt_done, 2);
        check("b2b_err_cnt", cnt_err, 0);
        check("b2b_out", int'(out), 'hFF);

        // 4-cycle low glitch on an idle line
        zero_counts();
        begin
            win_t w;
            w.lo = cyc + SYNC + 1;
            w.hi = cyc + SYNC + OS / 2;
            w.evt = 0;
            w.has_evt = 1'b0;
            w.is_done = 1'b0;
            w.val = 8'h00;
            wins.push_back(w);
        end
        in = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_busy_cycles", cnt_busy, 8);
        check("glitch_done_cnt", cnt_done, 0);
        check("glitch_err_cnt", cnt_err, 0);
        check("glitch_out", int'(out), 'hFF);

        // Framing error after a good byte, then line held low
        zero_counts();
        send_frame(8'h5A, 1'b1, -1);
        idle(4);
        send_frame(8'h3C, 1'b0, -1);
        check("ferr_err_cnt", cnt_err, 1);
        check("ferr_done_cnt", cnt_done, 1);
        check("ferr_out", int'(out), 'h5A);
        zero_counts();
        repeat (3 * OS) @(negedge clk);
        check("held_low_busy", cnt_busy, 0);
        idle(2 * OS);
        check("held_low_after_busy", cnt_busy, 0);

        // en low for a whole frame: ignored
        zero_counts();
        en = 1'b0;
        send_frame(8'h81, 1'b1, -1);
        idle(8);
        en = 1'b1;
        idle(4);
        check("en0_busy_cycles", cnt_busy, 0);
        check("en0_done_cnt", cnt_done, 0);

        // en dropped mid-frame: frame still completes
        zero_counts();
        send_frame(8'h81, 1'b1, 3);
        idle(8);
        en = 1'b1;
        check("endrop_done_cnt", cnt_done, 1);
        check("endrop_out", int'(out), 'h81);

        // Reset during data bit 4 of 0xC3
        zero_counts();
        add_frame(cyc, 8'hC3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in = frame_level(8'hC3, 1'b1, i);
            repeat (OS) @(negedge clk);
        end
        in = frame_level(8'hC3, 1'b1, 5);
        repeat (OS / 2) @(negedge clk);
        pulse_reset();
        idle(8);
        check("post_rst_out", int'(out), 0);
        zero_counts();
        send_frame(8'h7E, 1'b1, -1);
        idle(8);
        check("7e_done_cnt", cnt_done, 1);
        check("7e_err_cnt", cnt_err, 0);
        check("7e_out", int'(out), 'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
